ef_pin_mux_ctrl: RTL and testbench
==================================

# ef_pin_mux_ctrl

Sequencing controller for the per-pin function-select bus of the I/O pin multiplexer. It accepts one pin-reassignment request at a time over a valid/ready handshake. For each change it forces the pin's output driver off, switches the 2-bit function select, holds the driver off for a settle interval, then releases it, so no glitch or contention reaches the pad. It also owns per-pin lock bits that freeze a pin's assignment until reset.

## Interface

Parameters:
- COUNT, 16, number of muxed pins; legal range 1..16.
- GUARD, 4, cycles the driver is forced off before `sel` changes; must be ≥1.
- SETTLE, 2, cycles the driver stays forced off after `sel` changes; must be ≥1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_pin  in  4  target pin index.
- req_func  in  2  function to select (0..3).
- req_lock  in  1  lock the pin after a successful request.
- done  out  1  one-cycle pulse: request completed successfully.
- err  out  1  one-cycle pulse: request rejected.
- busy  out  1  high in any state other than IDLE.
- sel  out  COUNT*2  function select; pin i uses bits [2i+1:2i].
- oeb_force  out  COUNT  per-pin force-tristate; the top level ORs it into the pad `oeb`.
- lock  out  COUNT  per-pin lock status.

## Operation

- States: IDLE, DRAIN, SWITCH, SETTLE. One down-counter, width ≥ clog2(max(GUARD,SETTLE)+1).
- Handshake: a transfer occurs when `req_valid & req_ready`. Pin, func and lock are captured that cycle. The inputs are don't-care afterwards.
- Reject: the request is rejected if `req_pin ≥ COUNT` or `lock[req_pin]=1`. Then `err` pulses for one cycle, nothing else changes, and the state stays IDLE.
- Fast path: the request takes the fast path if it is accepted, not locked, and `req_func` equals the pin's current `sel`. Then `done` pulses, `lock[pin]` is set if `req_lock`, no force is applied, and the state stays IDLE.
- Full path: IDLE → DRAIN → SWITCH → SETTLE → IDLE.
  - IDLE → DRAIN: `oeb_force[pin]=1`, counter loaded with GUARD.
  - DRAIN: the state counts GUARD cycles.
  - SWITCH: on the last DRAIN cycle, `sel[pin]` is written with the captured func.
  - SETTLE: holds SETTLE cycles with force still high.
  - Exit: force clears, `done` pulses, `lock[pin]` is set if `req_lock`, and the state is IDLE.
- Only the addressed pin's `sel`, `oeb_force` and `lock` bits ever change. All other pins are untouched.
- Locks clear only on `rst`.
- `done` and `err` are never high in the same cycle.
- Reset values: `sel`=0 (function 0 on all pins), `oeb_force`=0, `lock`=0, `done`=0, `err`=0, `busy`=0, `req_ready`=1, state IDLE.

## Timing

Cycle 0 is the handshake cycle.

- Full path:
  - `req_ready`=0 and `busy`=1 in cycles 1..GUARD+SETTLE.
  - `oeb_force[pin]`=1 in cycles 1..GUARD+SETTLE.
  - New `sel` value is visible from cycle GUARD+1 on; force is already high ≥GUARD cycles by then.
  - `done`=1, `req_ready`=1, `busy`=0 and `oeb_force[pin]`=0 in cycle GUARD+SETTLE+1.
  - A new request may transfer in that same cycle.
- Fast path: `done`=1 in cycle 1 with `req_ready` staying 1. Back-to-back transfers are allowed every cycle.
- Reject: `err`=1 in cycle 1 with `req_ready` staying 1.
- `lock` updates are visible in the same cycle as `done`.
- `rst` asserted in any state: on the next edge every output takes its reset value. This includes reverting `sel` to 0 and dropping `oeb_force`, mid-operation or not. The in-flight request is discarded, with no `done` or `err`.
- `rst` has priority over a simultaneous handshake; the request is not accepted.

## Test plan

All scenarios use COUNT=16, GUARD=4, SETTLE=2.

1. Reset: hold `rst` 2 cycles, then release → `sel`=0, `oeb_force`=0, `lock`=0, `req_ready`=1, `done`/`err`=0.
2. Full switch: pin 3, func 2, cycle 0 →
   - `oeb_force[3]`=1 and `req_ready`=0 in cycles 1–6.
   - `sel[7:6]`=2 from cycle 5.
   - `done`=1 and `oeb_force[3]`=0 in cycle 7.
   - All other `sel` and `oeb_force` bits unchanged throughout.
3. Fast path and lock: pin 3 func 2 with `req_lock`=1 after scenario 2 → `done` in cycle 1, `lock[3]`=1, no force. A following request pin 3 func 0 → `err` in cycle 1, `sel[7:6]` stays 2.
4. Range error: `req_pin`=15 succeeds; `req_pin`=16 is not representable, so re-run with COUNT=8 and `req_pin`=8 → `err`=1 in cycle 1, no state change.
5. Back-to-back: `req_valid` held high with pin 5 func 1, then pin 6 func 3 → second transfer in cycle 7 (the `done` cycle of the first). Second `done` in cycle 14; `sel[11:10]`=1 and `sel[13:12]`=3.
6. Reset mid-operation: start pin 2 func 3, assert `rst` in cycle 3 (DRAIN) → from cycle 4 `oeb_force`=0 and `sel`=0; no `done` or `err`; `req_ready`=1 once `rst` drops.

Source files
------------

// File: rtl/ef_pin_mux_ctrl.sv
// Pin-mux function-select sequencer: forces the pad driver off around every
// select change and owns the per-pin lock bits that freeze an assignment.
module ef_pin_mux_ctrl #(
  parameter int COUNT  = 16,
  parameter int GUARD  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_pin,
  input  logic [1:0]         req_func,
  input  logic               req_lock,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [COUNT*2-1:0] sel,
  output logic [COUNT-1:0]   oeb_force,
  output logic [COUNT-1:0]   lock
);

  localparam int CNT_MAX = (GUARD > SETTLE) ? GUARD : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [4:0] COUNT5 = 5'(COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [3:0] pin_q;
  logic [1:0] func_q;
  logic       lock_q;

  logic        take_rej, take_fast, take_full, do_switch, do_finish;
  logic        pin_ok;
  logic [1:0]  cur_func;
  logic [31:0] sel_ext;
  logic [15:0] lock_ext;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Views padded to the full 16-pin index space so any 4-bit req_pin is a legal index.
  assign sel_ext  = 32'(sel);
  assign lock_ext = 16'(lock);
  assign pin_ok   = ({1'b0, req_pin} < COUNT5);
  assign cur_func = sel_ext[{req_pin, 1'b0} +: 2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_rej  = 1'b0;
    take_fast = 1'b0;
    take_full = 1'b0;
    do_switch = 1'b0;
    do_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!pin_ok || lock_ext[req_pin]) begin
            take_rej = 1'b1;
          end else if (cur_func == req_func) begin
            take_fast = 1'b1;
          end else begin
            // SWITCH is the final guard cycle, so DRAIN covers the first GUARD-1.
            take_full = 1'b1;
            state_nxt = (GUARD == 1) ? ST_SWITCH : ST_DRAIN;
            cnt_nxt   = CNT_W'(GUARD - 1);
          end
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        do_switch = 1'b1;
        state_nxt = ST_SETTLE;
        cnt_nxt   = CNT_W'(SETTLE);
      end
      ST_SETTLE: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          do_finish = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture is data only; it is meaningful solely while busy.
  always_ff @(posedge clk) begin
    if (take_full) begin
      pin_q  <= req_pin;
      func_q <= req_func;
      lock_q <= req_lock;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      oeb_force <= '0;
      lock      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= take_fast | do_finish;
      err  <= take_rej;
      for (int i = 0; i < COUNT; i++) begin
        if (take_full && req_pin == 4'(i)) oeb_force[i] <= 1'b1;
        if (do_finish && pin_q == 4'(i))   oeb_force[i] <= 1'b0;
        if (do_switch && pin_q == 4'(i))   sel[2*i +: 2] <= func_q;
        if (take_fast && req_lock && req_pin == 4'(i)) lock[i] <= 1'b1;
        if (do_finish && lock_q && pin_q == 4'(i))     lock[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ef_pin_mux_ctrl.sv
// Directed bench for ef_pin_mux_ctrl with a cycle-timeline reference model.
module tb_ef_pin_mux_ctrl;

  localparam int G = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_pin = '0;
  logic [1:0]  req_func = '0;
  logic        req_lock = 1'b0;
  logic        req_ready, done, err, busy;
  logic [31:0] sel;
  logic [15:0] oeb_force, lock;

  logic        v8 = 1'b0;
  logic [3:0]  pin8 = '0;
  logic [1:0]  func8 = '0;
  logic        lk8in = 1'b0;
  logic        ready8, done8, err8, busy8;
  logic [15:0] sel8;
  logic [7:0]  force8, lock8;

  always #5 clk = ~clk;

  ef_pin_mux_ctrl #(.COUNT(16), .GUARD(G), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pin(req_pin), .req_func(req_func), .req_lock(req_lock),
    .done(done), .err(err), .busy(busy), .sel(sel),
    .oeb_force(oeb_force), .lock(lock)
  );

  ef_pin_mux_ctrl #(.COUNT(8), .GUARD(G), .SETTLE(S)) dut8 (
    .clk(clk), .rst(rst), .req_valid(v8), .req_ready(ready8),
    .req_pin(pin8), .req_func(func8), .req_lock(lk8in),
    .done(done8), .err(err8), .busy(busy8), .sel(sel8),
    .oeb_force(force8), .lock(lock8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one in-flight change by cycles since its handshake.
  int exp_sel [16];
  bit exp_force [16];
  bit exp_lock [16];
  bit exp_done, exp_err;
  bit op_active;
  int op_pin, op_func, op_t;
  bit op_lock;

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_sel[i] = 0; exp_force[i] = 0; exp_lock[i] = 0;
    end
    exp_done = 0; exp_err = 0; op_active = 0;
    op_pin = 0; op_func = 0; op_t = 0; op_lock = 0;
    forever begin
      @(posedge clk);
      exp_done = 0;
      exp_err  = 0;
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          exp_sel[i] = 0; exp_force[i] = 0; exp_lock[i] = 0;
        end
        op_active = 0;
      end else begin
        automatic bit ready_c = !op_active;
        if (op_active) begin
          op_t++;
          if (op_t == G + 1) exp_sel[op_pin] = op_func;
          if (op_t == G + S + 1) begin
            exp_force[op_pin] = 0;
            exp_done = 1;
            if (op_lock) exp_lock[op_pin] = 1;
            op_active = 0;
          end
        end
        if (req_valid && ready_c) begin
          automatic int p = int'(req_pin);
          if (p >= 16 || exp_lock[p]) begin
            exp_err = 1;
          end else if (exp_sel[p] == int'(req_func)) begin
            exp_done = 1;
            if (req_lock) exp_lock[p] = 1;
          end else begin
            exp_force[p] = 1;
            op_active = 1; op_pin = p; op_func = int'(req_func);
            op_lock = req_lock; op_t = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [31:0] es;
      logic [15:0] ef, el;
      for (int i = 0; i < 16; i++) begin
        es[2*i +: 2] = 2'(exp_sel[i]);
        ef[i] = exp_force[i];
        el[i] = exp_lock[i];
      end
      check("model_sel", 64'(sel), 64'(es));
      check("model_force", 64'(oeb_force), 64'(ef));
      check("model_lock", 64'(lock), 64'(el));
      check("model_done", 64'(done), 64'(exp_done));
      check("model_err", 64'(err), 64'(exp_err));
      check("model_ready", 64'(req_ready), 64'(!op_active));
      check("model_busy", 64'(busy), 64'(op_active));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Scenario 1: reset
    tick(); tick();
    cmp_on = 1'b1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_sel", 64'(sel), 64'h0);
    check("rst_force", 64'(oeb_force), 64'h0);
    check("rst_lock", 64'(lock), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_done_err", 64'({done, err}), 64'h0);
    check("rst8_ready", 64'(ready8), 64'h1);

    // Scenario 2: full switch pin 3 -> func 2
    tick();
    req_valid = 1; req_pin = 3; req_func = 2; req_lock = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) req_valid = 0;
      @(negedge clk);
      check("full_force3", 64'(oeb_force), (k <= 6) ? 64'h0008 : 64'h0);
      check("full_ready", 64'(req_ready), (k <= 6) ? 64'h0 : 64'h1);
      check("full_sel", 64'(sel), (k >= 5) ? 64'h80 : 64'h0);
      check("full_done", 64'(done), (k == 7) ? 64'h1 : 64'h0);
    end

    // Scenario 3: fast path with lock, then locked reject
    tick();
    req_valid = 1; req_pin = 3; req_func = 2; req_lock = 1;
    tick();
    req_valid = 0; req_lock = 0;
    @(negedge clk);
    check("fast_done", 64'(done), 64'h1);
    check("fast_lock", 64'(lock), 64'h0008);
    check("fast_force", 64'(oeb_force), 64'h0);
    check("fast_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 1; req_pin = 3; req_func = 0;
    tick();
    req_valid = 0;
    @(negedge clk);
    check("lock_err", 64'({err, done}), 64'h2);
    check("lock_sel", 64'(sel), 64'h80);

    // Scenario 4: highest pin succeeds; out-of-range pin on 8-pin instance
    tick();
    req_valid = 1; req_pin = 15; req_func = 1;
    v8 = 1; pin8 = 8; func8 = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin req_valid = 0; v8 = 0; end
      @(negedge clk);
      if (k == 1) begin
        check("range8_err", 64'({err8, done8}), 64'h2);
        check("range8_state", 64'({sel8, force8, lock8, ready8}), 64'h1);
      end
      if (k == 7) begin
        check("pin15_done", 64'(done), 64'h1);
        check("pin15_sel", 64'(sel), 64'h4000_0080);
      end
    end

    // Scenario 5: back-to-back full switches, valid held high
    tick();
    req_valid = 1; req_pin = 5; req_func = 1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) begin req_pin = 6; req_func = 3; end
      if (k == 8) req_valid = 0;
      @(negedge clk);
      if (k == 7) check("b2b_first_done", 64'({done, req_ready}), 64'h3);
      if (k == 8) check("b2b_second_busy", 64'({busy, oeb_force[6]}), 64'h3);
      if (k == 14) begin
        check("b2b_second_done", 64'(done), 64'h1);
        check("b2b_sel", 64'(sel), 64'h4000_3480);
      end
    end

    // Scenario 6: reset during DRAIN
    tick();
    req_valid = 1; req_pin = 2; req_func = 3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) req_valid = 0;
      if (k == 3) rst = 1;
      if (k == 4) rst = 0;
      @(negedge clk);
      if (k == 2) check("mid_force", 64'(oeb_force), 64'h0004);
      if (k >= 4) begin
        check("mid_rst_outs", 64'({sel, oeb_force, lock}), 64'h0);
        check("mid_rst_flags", 64'({done, err, req_ready}), 64'h1);
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
